// File: rtl/dec_key_sched.sv
// dec_key_sched: AES-128 key expansion that broadcasts K0..K10 to the decryption rounds, one key per clock
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   key_start  in   1    pulse: capture key_in and start expansion (accepted in IDLE only)
//   key_in     in   128  cipher key, bit 127 = byte 0
//   busy       out  1    expansion in progress
//   done       out  1    one-cycle pulse after the last key is broadcast
//   rkey       out  128  round key being broadcast
//   addr       out  4    decryption round address for rkey (IDLE_ADDR when idle)
module dec_key_sched #(
    parameter logic [3:0] IDLE_ADDR = 4'hF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] rkey,
    output logic [3:0]   addr
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [79:0] RCON = 80'h01020408102040801b36;
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction
    state_t        state_q, state_d;
    logic [3:0]    rcnt_q, rcnt_d, addr_q, addr_d;
    logic [127:0]  key_q, key_d, rkey_q, rkey_d, key_nxt;
    logic          busy_q, busy_d, done_q, done_d;
    logic [31:0]   w4, w5, w6, w7, t;
    logic [7:0]    rcon;
    always_comb begin
        // rcnt parks at 10; the key computed there is discarded, so Rcon reads 0
        rcon = rcnt_q < 4'd10 ? RCON[79 - 8 * int'(rcnt_q) -: 8] : 8'h00;
        // SubWord(RotWord(w3)) with Rcon folded into the top byte
        t = {sbox(key_q[23:16]) ^ rcon, sbox(key_q[15:8]), sbox(key_q[7:0]), sbox(key_q[31:24])};
        w4 = key_q[127:96] ^ t;
        w5 = key_q[95:64] ^ w4;
        w6 = key_q[63:32] ^ w5;
        w7 = key_q[31:0] ^ w6;
        key_nxt = {w4, w5, w6, w7};
    end
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        key_d   = key_q;
        rkey_d  = 128'h0;
        addr_d  = IDLE_ADDR;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = key_start ? EXPAND : IDLE;
                key_d   = key_start ? key_in : key_q;
                rcnt_d  = key_start ? 4'd0 : rcnt_q;
                busy_d  = key_start;
            end
            EXPAND: begin
                rkey_d  = key_q;
                addr_d  = 4'd10 - rcnt_q;
                key_d   = key_nxt;
                rcnt_d  = rcnt_q == 4'd10 ? rcnt_q : rcnt_q + 4'd1;
                busy_d  = rcnt_q != 4'd10;
                state_d = rcnt_q == 4'd10 ? DONE : EXPAND;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rcnt_q  <= 4'd0;
            key_q   <= 128'h0;
            rkey_q  <= 128'h0;
            addr_q  <= IDLE_ADDR;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            key_q   <= key_d;
            rkey_q  <= rkey_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign rkey = rkey_q;
    assign addr = addr_q;
endmodule

// File: tb/tb_dec_key_sched.sv
// tb_dec_key_sched: directed self-checking bench for dec_key_sched
module tb_dec_key_sched;
    logic         clk, rst, key_start, busy, done;
    logic [127:0] key_in, rkey;
    logic [3:0]   addr;
    int tests = 0;
    int fails = 0;
    localparam logic [127:0] KA [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    dec_key_sched dut (
        .clk(clk), .rst(rst), .key_start(key_start), .key_in(key_in),
        .busy(busy), .done(done), .rkey(rkey), .addr(addr)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_addr"}, 128'(addr), 128'(4'hF));
        check({tag, "_rkey"}, rkey, 128'h0);
    endtask
    // full test-key expansion; optional ignored re-pulse at edge repulse_n and in the DONE cycle
    task automatic run_ka(input int repulse_n, input bit pulse_in_done);
        key_in = KA[0];
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        key_in = ~KA[0];
        check("start_busy", 128'(busy), 128'(1));
        check("start_addr", 128'(addr), 128'(4'hF));
        for (int n = 1; n <= 11; n++) begin
            if (n == repulse_n) begin
                key_start = 1'b1;
                key_in = 128'h0;
            end
            tick();
            key_start = 1'b0;
            check($sformatf("k%0d_rkey", n - 1), rkey, KA[n - 1]);
            check($sformatf("k%0d_addr", n - 1), 128'(addr), 128'(11 - n));
            check($sformatf("k%0d_busy", n - 1), 128'(busy), 128'(n <= 10));
            check($sformatf("k%0d_done", n - 1), 128'(done), 128'(0));
        end
        key_start = pulse_in_done;
        tick();
        key_start = 1'b0;
        check("done_pulse", 128'(done), 128'(1));
        check("done_busy", 128'(busy), 128'(0));
        check("done_addr", 128'(addr), 128'(4'hF));
        check("done_rkey", rkey, 128'h0);
        tick();
        check_idle("after_done");
        tick();
        check_idle("after_done2");
    endtask
    initial begin
        logic [127:0] k1, k10;
        int bc, dc;
        rst = 1'b1;
        key_start = 1'b0;
        key_in = 128'h0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        tick();
        check_idle("idle_hold");
        // FIPS-197 vector
        run_ka(0, 1'b0);
        // all-zero key
        key_in = 128'h0;
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        k1 = 128'h0;
        k10 = 128'h0;
        bc = 0;
        dc = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) bc++;
            if (addr == 4'd9) k1 = rkey;
            if (addr == 4'd0) k10 = rkey;
            if (done) begin
                dc++;
                break;
            end
            tick();
        end
        check("zero_k1", k1, 128'h62636363626363636263636362636363);
        check("zero_k10", k10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check("zero_busy_cycles", 128'(bc), 128'(11));
        check("zero_done_seen", 128'(dc), 128'(1));
        tick();
        check_idle("zero_end");
        // re-pulse mid-expansion and in the DONE cycle: both ignored
        run_ka(5, 1'b1);
        // reset mid-expansion
        key_in = KA[0];
        key_start = 1'b1;
        tick();
        key_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("pre_abort_addr", 128'(addr), 128'(6));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("abort_hold%0d", i));
        end
        run_ka(0, 1'b0);
        // key_start together with rst
        key_in = KA[0];
        key_start = 1'b1;
        rst = 1'b1;
        tick();
        key_start = 1'b0;
        rst = 1'b0;
        check_idle("rst_start");
        tick();
        check_idle("rst_start2");
        tick();
        check_idle("rst_start3");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
